// File: rtl/seg_display_mux_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment driver.
// Segment patterns are active-low, bit6 = a ... bit0 = g.
package seg_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0001100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/seg_display_mux_if.sv
// Bundle between the datapath (master) and the display driver (slave):
// digit/point/blank requests in, segment and anode pins out.
interface seg_display_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_suppress;
    logic [6:0]              segs;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_start;

    modport master (
        output digits_in, dp_in, blank_in, lz_suppress,
        input  segs, dp_n, an_n, frame_start
    );

    modport slave (
        input  digits_in, dp_in, blank_in, lz_suppress,
        output segs, dp_n, an_n, frame_start
    );
endinterface

// File: rtl/seg_display_mux_decode.sv
// Nibble to active-low seven-segment pattern; 10-15 blank unless hex_en is set.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] segs
);

    always_comb begin
        segs = SEG_BLANK;
        case (nibble)
            4'h0: segs = SEG_0;
            4'h1: segs = SEG_1;
            4'h2: segs = SEG_2;
            4'h3: segs = SEG_3;
            4'h4: segs = SEG_4;
            4'h5: segs = SEG_5;
            4'h6: segs = SEG_6;
            4'h7: segs = SEG_7;
            4'h8: segs = SEG_8;
            4'h9: segs = SEG_9;
            4'hA: segs = hex_en ? SEG_A : SEG_BLANK;
            4'hB: segs = hex_en ? SEG_B : SEG_BLANK;
            4'hC: segs = hex_en ? SEG_C : SEG_BLANK;
            4'hD: segs = hex_en ? SEG_D : SEG_BLANK;
            4'hE: segs = hex_en ? SEG_E : SEG_BLANK;
            4'hF: segs = hex_en ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode display driver: latch inputs once per frame,
// then scan digits with an all-off guard interval before each one.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_CYCLES   = 100000,
    parameter int GUARD_CYCLES = 64,
    parameter bit HEX_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    seg_display_mux_if.slave bus
);

    localparam int MAX_CYC = (DIV_CYCLES > GUARD_CYCLES) ? DIV_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_GUARD = GUARD;
    localparam logic [1:0] ST_DRIVE = DRIVE;

    if (NUM_DIGITS < 1) begin : g_bad_num_digits
        $error("NUM_DIGITS must be >= 1");
    end
    if (DIV_CYCLES < 1) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be >= 1");
    end
    if (GUARD_CYCLES < 1) begin : g_bad_guard_cycles
        $error("GUARD_CYCLES must be >= 1");
    end

    logic [1:0]              state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    load_fire;

    logic [4*NUM_DIGITS-1:0] shadow_digits_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [NUM_DIGITS-1:0]   shadow_blank_reg;
    logic                    shadow_lz_reg;

    logic [6:0]              segs_reg;
    logic                    dp_n_reg;
    logic [NUM_DIGITS-1:0]   an_n_reg;
    logic                    frame_start_reg;

    // A digit is leading-zero blanked when it and every digit above it are zero.
    logic [NUM_DIGITS-1:0] nz;
    logic [NUM_DIGITS-1:0] nz_from_top;
    logic [NUM_DIGITS-1:0] lz_mask;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign nz[gi] = |shadow_digits_reg[4*gi +: 4];
        if (gi == NUM_DIGITS - 1) begin : g_top
            assign nz_from_top[gi] = nz[gi];
        end else begin : g_rest
            assign nz_from_top[gi] = nz[gi] | nz_from_top[gi+1];
        end
        if (gi == 0) begin : g_d0
            assign lz_mask[gi] = 1'b0;
        end else begin : g_dn
            assign lz_mask[gi] = shadow_lz_reg & ~nz_from_top[gi];
        end
    end

    // LOAD with frame_start low is the post-reset hold: take one more cycle so
    // the first cycle after release is a real LOAD with frame_start high.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load_fire  = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                idx_next = '0;
                if (frame_start_reg) begin
                    state_next = ST_GUARD;
                    load_fire  = 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_reg == GUARD_LAST) state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cnt_reg == DIV_LAST) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next = ST_LOAD;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_GUARD;
                    end
                end
            end
            default: state_next = ST_LOAD;
        endcase
        cnt_next = (state_next != state_reg) ? '0 : cnt_reg + 1'b1;
    end

    logic [3:0] sel_nibble;
    logic [6:0] dec_segs;
    logic       sel_blank;

    assign sel_nibble = shadow_digits_reg[{idx_next, 2'b00} +: 4];
    assign sel_blank  = shadow_blank_reg[idx_next] | lz_mask[idx_next];

    seg_decode u_decode (
        .nibble (sel_nibble),
        .hex_en (HEX_EN),
        .segs   (dec_segs)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg         <= ST_LOAD;
            cnt_reg           <= '0;
            idx_reg           <= '0;
            shadow_digits_reg <= '0;
            shadow_dp_reg     <= '0;
            shadow_blank_reg  <= '0;
            shadow_lz_reg     <= 1'b0;
            segs_reg          <= SEG_BLANK;
            dp_n_reg          <= 1'b1;
            an_n_reg          <= '1;
            frame_start_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            frame_start_reg <= (state_next == ST_LOAD);
            if (load_fire) begin
                shadow_digits_reg <= bus.digits_in;
                shadow_dp_reg     <= bus.dp_in;
                shadow_blank_reg  <= bus.blank_in;
                shadow_lz_reg     <= bus.lz_suppress;
            end
            // Outputs follow the state being entered on this edge.
            if (state_next == ST_DRIVE) begin
                an_n_reg <= ~(NUM_DIGITS'(1) << idx_next);
                segs_reg <= sel_blank ? SEG_BLANK : dec_segs;
                dp_n_reg <= ~shadow_dp_reg[idx_next];
            end else begin
                an_n_reg <= '1;
                segs_reg <= SEG_BLANK;
                dp_n_reg <= 1'b1;
            end
        end
    end

    assign bus.segs        = segs_reg;
    assign bus.dp_n        = dp_n_reg;
    assign bus.an_n        = an_n_reg;
    assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with NUM_DIGITS=4, DIV_CYCLES=4, GUARD_CYCLES=2,
// plus a HEX_EN=0 twin sharing the same inputs.
module tb_seg_display_mux;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    seg_display_mux_if #(.NUM_DIGITS(4)) bus ();
    seg_display_mux_if #(.NUM_DIGITS(4)) bus_nohex ();

    assign bus_nohex.digits_in   = bus.digits_in;
    assign bus_nohex.dp_in       = bus.dp_in;
    assign bus_nohex.blank_in    = bus.blank_in;
    assign bus_nohex.lz_suppress = bus.lz_suppress;

    seg_display_mux #(.NUM_DIGITS(4), .DIV_CYCLES(4), .GUARD_CYCLES(2), .HEX_EN(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    seg_display_mux #(.NUM_DIGITS(4), .DIV_CYCLES(4), .GUARD_CYCLES(2), .HEX_EN(1'b0)) dut_nohex (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_nohex)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Frame offsets k=1..24 after the frame_start cycle: digit d guard at 6d+1..6d+2, drive at 6d+3..6d+6.
    logic [3:0] obs_an   [1:24];
    logic [6:0] obs_segs [1:24];
    logic       obs_dp   [1:24];
    logic [3:0] obs_an2  [1:24];
    logic [6:0] obs_segs2[1:24];

    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(~bus.an_n) > 1 || $countones(~bus_nohex.an_n) > 1) begin
                errors++;
                $display("FAIL one_anode: got an_n=%b / %b, want at most one bit low", bus.an_n, bus_nohex.an_n);
            end
        end
    end

    task automatic wait_frame();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL frame_start_timeout: got no frame_start in 100 cycles, want one every 25");
    endtask

    task automatic capture_frame(input int change_at, input logic [15:0] new_digits);
        wait_frame();
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == change_at) bus.digits_in = new_digits;
            obs_an[k]    = bus.an_n;
            obs_segs[k]  = bus.segs;
            obs_dp[k]    = bus.dp_n;
            obs_an2[k]   = bus_nohex.an_n;
            obs_segs2[k] = bus_nohex.segs;
        end
    endtask

    task automatic test_reset();
        int pulses;
        bus.digits_in   = 16'h1234;
        bus.dp_in       = 4'b0001;
        bus.blank_in    = 4'b0000;
        bus.lz_suppress = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.an_n !== 4'b1111 || bus.segs !== 7'h7F || bus.dp_n !== 1'b1 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got an_n=%b segs=%b dp_n=%b fs=%b, want 1111 1111111 1 0",
                     bus.an_n, bus.segs, bus.dp_n, bus.frame_start);
        end
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        checks++;
        if (bus.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL first_frame_start: got %b, want 1", bus.frame_start);
        end
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (bus.frame_start !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL frame_start_quiet: got %0d extra pulses, want 0", pulses);
        end
        @(negedge clk);
        checks++;
        if (bus.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: got frame_start=%b 25 cycles later, want 1", bus.frame_start);
        end
    endtask

    task automatic test_digits();
        logic [6:0] es [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        logic       ed [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        bus.digits_in = 16'h1234;
        bus.dp_in     = 4'b0001;
        capture_frame(0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            for (int k = 6*d+1; k <= 6*d+2; k++) begin
                checks++;
                if (obs_an[k] !== 4'b1111 || obs_segs[k] !== 7'h7F || obs_dp[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL digits_guard d%0d k%0d: got an=%b segs=%b dp_n=%b, want 1111 1111111 1",
                             d, k, obs_an[k], obs_segs[k], obs_dp[k]);
                end
            end
            for (int k = 6*d+3; k <= 6*d+6; k++) begin
                checks++;
                if (obs_an[k] !== an_exp[d] || obs_segs[k] !== es[d] || obs_dp[k] !== ed[d]) begin
                    errors++;
                    $display("FAIL digits_drive d%0d k%0d: got an=%b segs=%b dp_n=%b, want %b %b %b",
                             d, k, obs_an[k], obs_segs[k], obs_dp[k], an_exp[d], es[d], ed[d]);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] es1 [4] = '{7'b0000001, 7'b0001111, 7'h7F, 7'h7F};
        logic [6:0] es2 [4] = '{7'b0000001, 7'h7F, 7'h7F, 7'h7F};
        bus.digits_in   = 16'h0070;
        bus.dp_in       = 4'b0000;
        bus.lz_suppress = 1'b1;
        capture_frame(0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_an[6*d+4] !== an_exp[d] || obs_segs[6*d+4] !== es1[d] || obs_dp[6*d+4] !== 1'b1) begin
                errors++;
                $display("FAIL lz_0070 d%0d: got an=%b segs=%b dp_n=%b, want %b %b 1",
                         d, obs_an[6*d+4], obs_segs[6*d+4], obs_dp[6*d+4], an_exp[d], es1[d]);
            end
        end
        bus.digits_in = 16'h0000;
        capture_frame(0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_an[6*d+5] !== an_exp[d] || obs_segs[6*d+5] !== es2[d]) begin
                errors++;
                $display("FAIL lz_0000 d%0d: got an=%b segs=%b, want %b %b",
                         d, obs_an[6*d+5], obs_segs[6*d+5], an_exp[d], es2[d]);
            end
        end
        bus.lz_suppress = 1'b0;
    endtask

    task automatic test_hex();
        logic [6:0] es [4] = '{7'b0111000, 7'b0110001, 7'b1100000, 7'b0001000};
        bus.digits_in = 16'hABCF;
        capture_frame(0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_an[6*d+3] !== an_exp[d] || obs_segs[6*d+3] !== es[d]) begin
                errors++;
                $display("FAIL hex_en1 d%0d: got an=%b segs=%b, want %b %b",
                         d, obs_an[6*d+3], obs_segs[6*d+3], an_exp[d], es[d]);
            end
            checks++;
            if (obs_an2[6*d+3] !== an_exp[d] || obs_segs2[6*d+3] !== 7'h7F) begin
                errors++;
                $display("FAIL hex_en0 d%0d: got an=%b segs=%b, want %b 1111111",
                         d, obs_an2[6*d+3], obs_segs2[6*d+3], an_exp[d]);
            end
        end
    endtask

    task automatic test_blank();
        logic [6:0] es [4] = '{7'b0000000, 7'b0000000, 7'h7F, 7'b0000000};
        logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bus.digits_in = 16'h8888;
        bus.blank_in  = 4'b0100;
        bus.dp_in     = 4'b0100;
        capture_frame(0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_an[6*d+6] !== an_exp[d] || obs_segs[6*d+6] !== es[d] || obs_dp[6*d+6] !== ed[d]) begin
                errors++;
                $display("FAIL blank d%0d: got an=%b segs=%b dp_n=%b, want %b %b %b",
                         d, obs_an[6*d+6], obs_segs[6*d+6], obs_dp[6*d+6], an_exp[d], es[d], ed[d]);
            end
        end
        bus.blank_in = 4'b0000;
        bus.dp_in    = 4'b0000;
    endtask

    task automatic test_tearing();
        bus.digits_in = 16'h1111;
        capture_frame(10, 16'h2222);
        for (int d = 0; d < 4; d++) begin
            for (int k = 6*d+3; k <= 6*d+6; k++) begin
                checks++;
                if (obs_an[k] !== an_exp[d] || obs_segs[k] !== 7'b1001111) begin
                    errors++;
                    $display("FAIL tearing_old d%0d k%0d: got an=%b segs=%b, want %b 1001111",
                             d, k, obs_an[k], obs_segs[k], an_exp[d]);
                end
            end
        end
        capture_frame(0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_an[6*d+3] !== an_exp[d] || obs_segs[6*d+3] !== 7'b0010010) begin
                errors++;
                $display("FAIL tearing_new d%0d: got an=%b segs=%b, want %b 0010010",
                         d, obs_an[6*d+3], obs_segs[6*d+3], an_exp[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_frame();
        repeat (15) @(negedge clk);
        checks++;
        if (bus.an_n !== 4'b1011) begin
            errors++;
            $display("FAIL mid_drive_d2: got an_n=%b, want 1011", bus.an_n);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.an_n !== 4'b1111 || bus.segs !== 7'h7F || bus.dp_n !== 1'b1 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got an_n=%b segs=%b dp_n=%b fs=%b, want 1111 1111111 1 0",
                     bus.an_n, bus.segs, bus.dp_n, bus.frame_start);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.frame_start !== 1'b1 || bus.an_n !== 4'b1111) begin
            errors++;
            $display("FAIL mid_reset_release: got fs=%b an_n=%b, want 1 1111", bus.frame_start, bus.an_n);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.an_n !== 4'b1110 || bus.segs !== 7'b0010010) begin
            errors++;
            $display("FAIL mid_reset_resume: got an_n=%b segs=%b, want 1110 0010010", bus.an_n, bus.segs);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_lz();
        test_hex();
        test_blank();
        test_tearing();
        test_reset_mid();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Takes packed BCD/hex nibbles, decimal points and blanking controls, and scans one digit at a time.
- Inserts a guard interval between digits and latches inputs once per frame so the display never tears.
- Sits between the datapath and the FPGA display pins. It replaces the single-digit decoder plus external anode logic.

## Interface

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; must be ≥1.
- DIV_CYCLES, 100000, clock cycles each digit is driven; must be ≥1.
- GUARD_CYCLES, 64, cycles with all anodes off before each digit; must be ≥1.
- HEX_EN, 1, 1 = decode 10–15 as A b C d E F; 0 = blank them.

Ports:
- clk  in  1  system clock; one clock domain only.
- reset_n  in  1  reset, synchronous, active-low.
- digits_in  in  4*NUM_DIGITS  nibble i drives digit i; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  per-digit forced blank, 1 = blank.
- lz_suppress  in  1  1 = suppress leading zeros.
- segs  out  7  active-low segments; bit6 = a … bit0 = g.
- dp_n  out  1  active-low decimal point.
- an_n  out  NUM_DIGITS  active-low digit enables; at most one bit low.
- frame_start  out  1  one-cycle pulse when inputs are latched.

## Operation

- State machine with three states: LOAD, GUARD, DRIVE.
- Reset state is LOAD with idx=0 and the counter at 0.
- Reset outputs: an_n all 1, segs 7'h7F, dp_n 1, frame_start 0; shadow registers cleared to 0.
- LOAD (1 cycle):
  - Captures digits_in, dp_in, blank_in and lz_suppress into shadow registers.
  - Sets idx=0, then goes to GUARD.
- GUARD:
  - an_n all 1, segs 7'h7F, dp_n 1.
  - Stays for GUARD_CYCLES cycles, then goes to DRIVE.
- DRIVE:
  - an_n[idx]=0; segs and dp_n come from shadow digit idx.
  - Stays for DIV_CYCLES cycles.
  - At the end: if idx==NUM_DIGITS-1, go to LOAD; otherwise idx+1 and go to GUARD.
- Decode:
  - 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100.
  - A–F with HEX_EN=1: 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
  - A–F with HEX_EN=0: 1111111.
- Blanking:
  - Digit i is blank if shadow blank[i]=1.
  - Digit i is also blank if shadow lz=1, i≠0, and nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never zero-suppressed.
  - A blank digit drives segs=7'h7F; its anode is still asserted and dp_n still follows shadow dp[i].
- Inputs are read only in LOAD. Changes mid-frame take effect in the next frame.

## Timing

- All outputs are registered. Each output reflects the state entered on the same clock edge.
- frame_start is high exactly during the LOAD cycle.
- Frame length is NUM_DIGITS*(GUARD_CYCLES+DIV_CYCLES)+1 cycles.
- After reset release, the first cycle is LOAD, so frame_start=1.
- The first anode goes low GUARD_CYCLES+1 cycles after LOAD.
- Counter width is $clog2(max(DIV_CYCLES,GUARD_CYCLES)). The counter resets to 0 on every state change.
- Boundaries:
  - Exactly one anode-low interval per DRIVE.
  - Never two anodes low at once; the guard is always present between digits.
  - idx wraps from NUM_DIGITS-1 to 0 only via LOAD.
  - With NUM_DIGITS=1 the sequence is LOAD, GUARD, DRIVE, LOAD …
- Reset mid-operation: on the first edge with reset_n=0, return to reset state and reset output values regardless of state. Reset dominates all transitions.
- Parameter violations (values <1) fail elaboration.

## Structure

- Package seg_pkg holds:
  - typedef enum state_t {LOAD, GUARD, DRIVE};
  - localparam SEG_BLANK = 7'h7F;
  - segment constants for 0–F.
- One combinational sub-module, seg_decode: 4-bit nibble and HEX_EN in, 7-bit active-low segs out.
- Leading-zero mask is combinational in the top: a prefix-OR of the nonzero flags from the MSB down.
- The top holds the FSM, counter, idx, shadow registers and output registers.

## Test plan

Default bench parameters: NUM_DIGITS=4, DIV_CYCLES=4, GUARD_CYCLES=2.

1. Reset: hold reset_n=0 for 3 cycles → an_n=1111, segs=7F, dp_n=1, frame_start=0. In the first cycle after release, frame_start=1 and repeats every 25 cycles.
2. digits_in=16'h1234, lz=0, dp_in=0001 → after 2 guard cycles, an_n=1110 with segs=1001100 and dp_n=0 for 4 cycles. Then 2 cycles with all anodes off. Then an_n=1101 with segs=0000110. Digits 2 and 3 follow (0010010, 1001111).
3. lz=1, digits_in=16'h0070 → digits 3 and 2 segs=7F with anodes still low; digit 1 shows 0001111; digit 0 shows 0000001. With 16'h0000, only digit 0 shows 0000001.
4. digits_in=16'hABCF → HEX_EN=1 gives F, C, b, A codes per the Operation table. HEX_EN=0 gives 7F on all four digits.
5. Tearing: change digits_in from 16'h1111 to 16'h2222 during DRIVE of digit 1 → remaining digits still show 1 (1001111). 2 (0010010) appears only after the next frame_start.
6. Reset mid-DRIVE of digit 2 → on the next edge, an_n=1111 and segs=7F. After release, LOAD and frame_start=1; the assertion "never more than one an_n bit low" holds throughout.
